// File: rtl/uart_boot_loader_pkg.sv
// Shared types and constants for the framed UART boot loader.
package uart_boot_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    PAYLOAD,
    CHECK,
    DONE,
    ERROR
  } loader_state_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_CSUM    = 2'd1,
    ERR_LEN     = 2'd2,
    ERR_TIMEOUT = 2'd3
  } loader_err_e;

  localparam logic [7:0] BOOT_SYNC_BYTE = 8'hA5;

  // Lane index width; a single-byte word still needs a 1-bit (always zero) index.
  function automatic int unsigned lane_width(input int unsigned word_bytes);
    return (word_bytes > 1) ? $clog2(word_bytes) : 1;
  endfunction

endpackage

// File: rtl/uart_boot_loader_packer.sv
// boot_word_packer: gathers payload bytes into little-endian words and emits
// a registered one-cycle write with byte enables for the filled lanes.
module boot_word_packer
  import uart_boot_loader_pkg::*;
#(
  parameter int unsigned WORD_BYTES = 4,
  localparam int unsigned LANE_W = lane_width(WORD_BYTES)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    clear,
  input  logic                    byte_valid,
  input  logic [7:0]              byte_in,
  input  logic [LANE_W-1:0]       lane,
  input  logic                    flush,
  output logic                    we,
  output logic [8*WORD_BYTES-1:0] wdata,
  output logic [WORD_BYTES-1:0]   be
);

  logic [8*WORD_BYTES-1:0] acc_reg;
  logic [WORD_BYTES-1:0]   acc_be_reg;
  logic [8*WORD_BYTES-1:0] merged_data;
  logic [WORD_BYTES-1:0]   lane_sel;
  logic [WORD_BYTES-1:0]   merged_be;
  logic                    we_reg;
  logic [8*WORD_BYTES-1:0] wdata_reg;
  logic [WORD_BYTES-1:0]   be_reg;

  genvar gi;
  generate
    for (gi = 0; gi < WORD_BYTES; gi++) begin : g_lane
      assign lane_sel[gi] = byte_valid && (lane == LANE_W'(gi));
      assign merged_data[gi*8 +: 8] = lane_sel[gi] ? byte_in : acc_reg[gi*8 +: 8];
    end
  endgenerate

  assign merged_be = acc_be_reg | lane_sel;

  // Accumulator empties after each write so unfilled lanes of a short word read 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_reg    <= '0;
      acc_be_reg <= '0;
      we_reg     <= 1'b0;
      wdata_reg  <= '0;
      be_reg     <= '0;
    end else begin
      we_reg <= 1'b0;
      if (clear) begin
        acc_reg    <= '0;
        acc_be_reg <= '0;
      end else if (byte_valid) begin
        if (flush || lane_sel[WORD_BYTES-1]) begin
          we_reg     <= 1'b1;
          wdata_reg  <= merged_data;
          be_reg     <= merged_be;
          acc_reg    <= '0;
          acc_be_reg <= '0;
        end else begin
          acc_reg    <= merged_data;
          acc_be_reg <= merged_be;
        end
      end
    end
  end

  assign we    = we_reg;
  assign wdata = wdata_reg;
  assign be    = be_reg;

endmodule

// File: rtl/uart_boot_loader.sv
// Framed UART program loader: sync, 16-bit length, payload, 8-bit checksum.
// Define UART_BOOT_TIMEOUT_EN to build the inter-byte gap timeout (err_code 3).
module uart_boot_loader
  import uart_boot_loader_pkg::*;
#(
  parameter int unsigned WORD_BYTES     = 4,
  parameter int unsigned ADDR_W         = 10,
  parameter logic [7:0]  SYNC_BYTE      = BOOT_SYNC_BYTE,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    rx_valid,
  input  logic [7:0]              rx_data,
  output logic                    mem_we,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [8*WORD_BYTES-1:0] mem_wdata,
  output logic [WORD_BYTES-1:0]   mem_be,
  output logic                    cpu_reset_n,
  output logic                    load_busy,
  output logic                    load_done,
  output logic                    load_err,
  output logic [1:0]              err_code,
  output logic [7:0]              last_byte
);

  localparam int unsigned LANE_W = lane_width(WORD_BYTES);
  localparam logic [31:0] CAP_BYTES = 32'(WORD_BYTES) << ADDR_W;

  loader_state_e     state_reg, state_next;
  loader_err_e       err_reg, err_next;
  logic [7:0]        last_byte_reg;
  logic [7:0]        len_lo_reg;
  logic [15:0]       len_reg;
  logic [15:0]       byte_cnt_reg;
  logic [7:0]        csum_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [15:0]       len_full;
  logic              last_payload;
  logic [LANE_W-1:0] lane;
  logic              timeout_hit;

  assign len_full     = {rx_data, len_lo_reg};
  assign last_payload = ({1'b0, byte_cnt_reg} + 17'd1) == {1'b0, len_reg};
  assign lane         = (WORD_BYTES == 1) ? '0 : byte_cnt_reg[LANE_W-1:0];

`ifdef UART_BOOT_TIMEOUT_EN
  logic [31:0] gap_cnt_reg;

  // A byte arriving on the saturating cycle wins over the timeout.
  assign timeout_hit = load_busy && !rx_valid && (gap_cnt_reg == 32'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gap_cnt_reg <= '0;
    end else if (rx_valid || !load_busy) begin
      gap_cnt_reg <= '0;
    end else begin
      gap_cnt_reg <= gap_cnt_reg + 32'd1;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign timeout_hit    = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      err_reg   <= ERR_NONE;
    end else begin
      state_reg <= state_next;
      err_reg   <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    err_next   = err_reg;
    if (rx_valid) begin
      case (state_reg)
        IDLE:    if (rx_data == SYNC_BYTE) state_next = LEN_LO;
        LEN_LO:  state_next = LEN_HI;
        LEN_HI: begin
          if ({16'd0, len_full} > CAP_BYTES) begin
            state_next = ERROR;
            err_next   = ERR_LEN;
          end else if (len_full == 16'd0) begin
            state_next = CHECK;
          end else begin
            state_next = PAYLOAD;
          end
        end
        PAYLOAD: if (last_payload) state_next = CHECK;
        CHECK: begin
          if (rx_data == csum_reg) begin
            state_next = DONE;
          end else begin
            state_next = ERROR;
            err_next   = ERR_CSUM;
          end
        end
        DONE:    if (rx_data == SYNC_BYTE) state_next = LEN_LO;
        ERROR: begin
          if (rx_data == SYNC_BYTE) begin
            state_next = LEN_LO;
            err_next   = ERR_NONE;
          end
        end
        default: state_next = IDLE;
      endcase
    end else if (timeout_hit) begin
      state_next = ERROR;
      err_next   = ERR_TIMEOUT;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_byte_reg <= '0;
      len_lo_reg    <= '0;
      len_reg       <= '0;
      byte_cnt_reg  <= '0;
      csum_reg      <= '0;
      addr_reg      <= '0;
    end else begin
      if (rx_valid) last_byte_reg <= rx_data;
      if (mem_we) addr_reg <= addr_reg + 1'b1;
      if (rx_valid) begin
        case (state_reg)
          LEN_LO:  len_lo_reg <= rx_data;
          LEN_HI: begin
            len_reg      <= len_full;
            byte_cnt_reg <= '0;
            csum_reg     <= '0;
            addr_reg     <= '0;
          end
          PAYLOAD: begin
            byte_cnt_reg <= byte_cnt_reg + 16'd1;
            csum_reg     <= csum_reg + rx_data;
          end
          default: ;
        endcase
      end
    end
  end

  boot_word_packer #(
    .WORD_BYTES(WORD_BYTES)
  ) u_packer (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (rx_valid && (state_reg == LEN_HI)),
    .byte_valid(rx_valid && (state_reg == PAYLOAD)),
    .byte_in   (rx_data),
    .lane      (lane),
    .flush     (last_payload),
    .we        (mem_we),
    .wdata     (mem_wdata),
    .be        (mem_be)
  );

  assign mem_addr    = addr_reg;
  assign load_busy   = (state_reg == LEN_LO) || (state_reg == LEN_HI) ||
                       (state_reg == PAYLOAD) || (state_reg == CHECK);
  assign load_done   = (state_reg == DONE);
  assign load_err    = (state_reg == ERROR);
  assign cpu_reset_n = load_done;
  assign err_code    = err_reg;
  assign last_byte   = last_byte_reg;

endmodule

// File: tb/tb_uart_boot_loader.sv
// Directed bench for uart_boot_loader (WORD_BYTES=4, ADDR_W=10, TIMEOUT_CYCLES=100).
module tb_uart_boot_loader;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        cpu_reset_n;
  logic        load_busy;
  logic        load_done;
  logic        load_err;
  logic [1:0]  err_code;
  logic [7:0]  last_byte;

  int total = 0;
  int bad = 0;
  int wr_count = 0;
  int wr_mark;

  logic        we_s;
  logic [9:0]  addr_s;
  logic [31:0] wdata_s;
  logic [3:0]  be_s;

  always #5 clk = ~clk;

  uart_boot_loader #(
    .WORD_BYTES(4),
    .ADDR_W(10),
    .SYNC_BYTE(8'hA5),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_be     (mem_be),
    .cpu_reset_n(cpu_reset_n),
    .load_busy  (load_busy),
    .load_done  (load_done),
    .load_err   (load_err),
    .err_code   (err_code),
    .last_byte  (last_byte)
  );

  always @(negedge clk) begin
    if (reset_n && mem_we) wr_count++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One strobe, then two idle cycles; write outputs captured one cycle after the strobe.
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
    we_s     = mem_we;
    addr_s   = mem_addr;
    wdata_s  = mem_wdata;
    be_s     = mem_be;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic check_write(input string tag, input logic [9:0] addr,
                             input logic [31:0] data, input logic [3:0] be);
    check({tag, "_we"}, 64'(we_s), 64'd1);
    check({tag, "_addr"}, 64'(addr_s), 64'(addr));
    check({tag, "_data"}, 64'(wdata_s), 64'(data));
    check({tag, "_be"}, 64'(be_s), 64'(be));
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_cpu_reset_n", 64'(cpu_reset_n), 64'd0);
    check("rst_busy_done_err", 64'({load_busy, load_done, load_err}), 64'd0);
    check("rst_err_code", 64'(err_code), 64'd0);
    check("rst_mem_we", 64'(mem_we), 64'd0);
    check("rst_last_byte", 64'(last_byte), 64'd0);
    reset_n = 1'b1;
    $display("step: reset released");

    // Garbage before sync is ignored but still shows on last_byte
    send_byte(8'h00);
    send_byte(8'hFF);
    check("garbage_busy", 64'(load_busy), 64'd0);
    check("garbage_last_byte", 64'(last_byte), 64'hFF);
    $display("step: garbage bytes ignored");

    // Frame 1: 8 payload bytes, two full words, checksum 0x64
    send_byte(8'hA5);
    check("f1_busy_after_sync", 64'(load_busy), 64'd1);
    send_byte(8'h08); send_byte(8'h00);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    check("f1_no_partial_write", 64'(we_s), 64'd0);
    send_byte(8'h44);
    check_write("f1_w0", 10'd0, 32'h44332211, 4'hF);
    send_byte(8'h55); send_byte(8'h66); send_byte(8'h77); send_byte(8'h88);
    check_write("f1_w1", 10'd1, 32'h88776655, 4'hF);
    check("f1_cpu_held_before_check", 64'(cpu_reset_n), 64'd0);
    send_byte(8'h64);
    check("f1_done", 64'(load_done), 64'd1);
    check("f1_cpu_reset_n", 64'(cpu_reset_n), 64'd1);
    check("f1_last_byte", 64'(last_byte), 64'h64);
    check("f1_err_code", 64'(err_code), 64'd0);
    $display("step: frame 1 loaded");

    // Reload from DONE, frame 2: 5 bytes, final partial word
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = 8'hA5;
    @(negedge clk);
    rx_valid = 1'b0;
    check("reload_cpu_reset_low", 64'(cpu_reset_n), 64'd0);
    check("reload_busy", 64'(load_busy), 64'd1);
    repeat (2) @(negedge clk);
    send_byte(8'h05); send_byte(8'h00);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    check_write("f2_w0", 10'd0, 32'h04030201, 4'hF);
    send_byte(8'h05);
    check_write("f2_w1", 10'd1, 32'h00000005, 4'h1);
    send_byte(8'h0F);
    check("f2_done", 64'(load_done), 64'd1);
    $display("step: frame 2 loaded after reload");

    // Frame 3: bad checksum
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h10); send_byte(8'h20);
    check_write("f3_w0", 10'd0, 32'h00002010, 4'h3);
    send_byte(8'h31);
    check("f3_err", 64'(load_err), 64'd1);
    check("f3_err_code", 64'(err_code), 64'd1);
    check("f3_cpu_reset_n", 64'(cpu_reset_n), 64'd0);
    $display("step: bad checksum frame rejected");

    // Frame 4: recovery from ERROR
    send_byte(8'hA5);
    check("f4_err_cleared", 64'(err_code), 64'd0);
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h7E); send_byte(8'h7E);
    check("f4_done", 64'(load_done), 64'd1);
    check("f4_err_code", 64'(err_code), 64'd0);
    $display("step: recovered after error");

    // Length overflow: 4097 bytes
    wr_mark = wr_count;
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h10);
    check("ovf_err", 64'(load_err), 64'd1);
    check("ovf_err_code", 64'(err_code), 64'd2);
    check("ovf_busy", 64'(load_busy), 64'd0);
    check("ovf_no_write", 64'(wr_count - wr_mark), 64'd0);
    $display("step: oversized length rejected");

    // Zero length frame
    wr_mark = wr_count;
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    check("len0_done", 64'(load_done), 64'd1);
    check("len0_no_write", 64'(wr_count - wr_mark), 64'd0);
    $display("step: zero-length frame");

    // Sync value inside length/payload/checksum is data
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00); send_byte(8'hA5);
    check_write("syncdata_w0", 10'd0, 32'h000000A5, 4'h1);
    send_byte(8'hA5);
    check("syncdata_done", 64'(load_done), 64'd1);
    $display("step: sync byte treated as data");

    // Full-capacity frame: 4096 bytes, byte i = i mod 256, checksum 0
    wr_mark = wr_count;
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h10);
    check("cap_accepted", 64'({load_busy, load_err}), 64'b10);
    for (int i = 0; i < 4096; i++) send_byte(8'(i));
    check_write("cap_last", 10'h3FF, 32'hFFFEFDFC, 4'hF);
    check("cap_write_count", 64'(wr_count - wr_mark), 64'd1024);
    send_byte(8'h00);
    check("cap_done", 64'(load_done), 64'd1);
    $display("step: full-capacity frame");

    // Stalled frame
    send_byte(8'hA5); send_byte(8'h04); send_byte(8'h00); send_byte(8'h01);
    repeat (80) @(negedge clk);
    check("stall_still_busy", 64'(load_busy), 64'd1);
    repeat (40) @(negedge clk);
`ifdef UART_BOOT_TIMEOUT_EN
    check("timeout_err", 64'(load_err), 64'd1);
    check("timeout_err_code", 64'(err_code), 64'd3);
`else
    check("no_timeout_busy", 64'(load_busy), 64'd1);
    check("no_timeout_err_code", 64'(err_code), 64'd0);
`endif
    $display("step: stalled frame");

    // Async reset mid-frame: outputs clear without a clock edge
    send_byte(8'hA5); send_byte(8'h04); send_byte(8'h00); send_byte(8'h09);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("areset_busy_done_err", 64'({load_busy, load_done, load_err}), 64'd0);
    check("areset_cpu_reset_n", 64'(cpu_reset_n), 64'd0);
    check("areset_err_code", 64'(err_code), 64'd0);
    check("areset_last_byte", 64'(last_byte), 64'd0);
    check("areset_mem_we", 64'(mem_we), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    $display("step: async reset mid-frame");

    // Clean load after reset
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00); send_byte(8'h3C);
    check_write("post_rst_w0", 10'd0, 32'h0000003C, 4'h1);
    send_byte(8'h3C);
    check("post_rst_done", 64'(load_done), 64'd1);
    $display("step: load after reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
